pc_gen: RTL and testbench

- Parametrised successor of the combinational next-PC select.
- Owns the PC register and selects the next PC from five sources plus an external redirect.
- Fetch to instruction memory uses a req/gnt handshake.
- Detects misaligned control-flow targets and either traps or halts, and counts retired instructions.
- Sits between the control unit/ALU target logic and instruction memory in the single-cycle core.

---
 rtl/pc_gen.sv | 123 ++++++++++++
 tb/tb_pc_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program counter generator: owns the PC, picks the next fetch address, handles
// misaligned control-flow targets and pending interrupt redirects, counts retirements.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32,
    parameter bit              TRAP_EN      = 1'b1,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       pc_src,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [XLEN-1:0]  jal_target,
    input  logic [XLEN-1:0]  jalr_target,
    input  logic [XLEN-1:0]  epc,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic             irq_req,
    input  logic             fetch_gnt,
    output logic             fetch_req,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             misaligned_exc,
    output logic [XLEN-1:0]  bad_addr,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int              ALIGN_BITS = (IALIGN == 16) ? 1 : 2;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

    state_t           r_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_bad_addr;
    logic [CNT_W-1:0] r_instret;
    logic             r_mexc;
    logic             r_irq_pend;

    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_cand;
    logic [XLEN-1:0]  w_trap;
    logic             w_chk;
    logic             w_mis;
    logic             w_advance;
    logic             w_irq;

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_trap     = trap_vec & ALIGN_MASK;

    // Unused encodings fall back to sequential fetch; pc+4 is never alignment-checked.
    always_comb begin
        w_cand = w_pc_plus4;
        w_chk  = 1'b0;
        case (pc_src)
            3'b001: begin w_cand = branch_target;             w_chk = 1'b1; end
            3'b010: begin w_cand = jal_target;                w_chk = 1'b1; end
            3'b011: begin w_cand = jalr_target & ~XLEN'(1);   w_chk = 1'b1; end
            3'b100: begin w_cand = epc;                       w_chk = 1'b1; end
            default: begin w_cand = w_pc_plus4;               w_chk = 1'b0; end
        endcase
    end

    assign w_mis     = w_chk & ((IALIGN == 16) ? w_cand[0] : (w_cand[1:0] != 2'b00));
    assign w_advance = fetch_req & fetch_gnt & ~stall;
    assign w_irq     = r_irq_pend | irq_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_bad_addr <= '0;
            r_instret  <= '0;
            r_mexc     <= 1'b0;
            r_irq_pend <= 1'b0;
        end else begin
            r_mexc <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                    if (irq_req) r_irq_pend <= 1'b1;
                end
                ST_RUN: begin
                    if (w_advance) begin
                        // Interrupt beats a faulting target; a faulting target never retires.
                        if (w_irq) begin
                            r_pc       <= w_trap;
                            r_irq_pend <= 1'b0;
                            r_instret  <= r_instret + CNT_W'(1);
                        end else if (w_mis) begin
                            r_bad_addr <= w_cand;
                            r_mexc     <= 1'b1;
                            if (TRAP_EN) r_pc    <= w_trap;
                            else         r_state <= ST_HALT;
                        end else begin
                            r_pc      <= w_cand;
                            r_instret <= r_instret + CNT_W'(1);
                        end
                    end else if (irq_req) begin
                        r_irq_pend <= 1'b1;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign fetch_req      = (r_state == ST_RUN);
    assign halted         = (r_state == ST_HALT);
    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign misaligned_exc = r_mexc;
    assign bad_addr       = r_bad_addr;
    assign instret        = r_instret;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: three instances (trap/IALIGN32, trap/IALIGN16 with a
// 2-bit counter, halt/IALIGN32) share stimulus; expectations go through a scoreboard queue.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  pc_src;
    logic [31:0] branch_target, jal_target, jalr_target, epc, trap_vec;
    logic        irq_req;
    logic        fetch_gnt;

    logic        a_freq, a_mexc, a_halted;
    logic [31:0] a_pc, a_pc4, a_bad, a_ir;
    logic        b_freq, b_mexc, b_halted;
    logic [31:0] b_pc, b_pc4, b_bad;
    logic [1:0]  b_ir;
    logic        c_freq, c_mexc, c_halted;
    logic [31:0] c_pc, c_pc4, c_bad, c_ir;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0100), .IALIGN(32), .TRAP_EN(1'b1), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
        .branch_target(branch_target), .jal_target(jal_target), .jalr_target(jalr_target),
        .epc(epc), .trap_vec(trap_vec), .irq_req(irq_req), .fetch_gnt(fetch_gnt),
        .fetch_req(a_freq), .pc(a_pc), .pc_plus4(a_pc4), .misaligned_exc(a_mexc),
        .bad_addr(a_bad), .halted(a_halted), .instret(a_ir));

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0100), .IALIGN(16), .TRAP_EN(1'b1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
        .branch_target(branch_target), .jal_target(jal_target), .jalr_target(jalr_target),
        .epc(epc), .trap_vec(trap_vec), .irq_req(irq_req), .fetch_gnt(fetch_gnt),
        .fetch_req(b_freq), .pc(b_pc), .pc_plus4(b_pc4), .misaligned_exc(b_mexc),
        .bad_addr(b_bad), .halted(b_halted), .instret(b_ir));

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0100), .IALIGN(32), .TRAP_EN(1'b0), .CNT_W(32)) u_c (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
        .branch_target(branch_target), .jal_target(jal_target), .jalr_target(jalr_target),
        .epc(epc), .trap_vec(trap_vec), .irq_req(irq_req), .fetch_gnt(fetch_gnt),
        .fetch_req(c_freq), .pc(c_pc), .pc_plus4(c_pc4), .misaligned_exc(c_mexc),
        .bad_addr(c_bad), .halted(c_halted), .instret(c_ir));

    localparam int A_PC = 0, A_IR = 1, A_FREQ = 2, A_MEXC = 3, A_BAD = 4, A_HALT = 5, A_PC4 = 6;
    localparam int B_PC = 10, B_IR = 11, B_MEXC = 13;
    localparam int C_PC = 20, C_IR = 21, C_FREQ = 22, C_MEXC = 23, C_BAD = 24, C_HALT = 25;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [31:0] e_pc_a, e_pc_b, e_pc_c, e_ir_a, e_ir_c;
    logic [1:0]  e_ir_b;

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            A_PC:    return a_pc;
            A_IR:    return a_ir;
            A_FREQ:  return {31'd0, a_freq};
            A_MEXC:  return {31'd0, a_mexc};
            A_BAD:   return a_bad;
            A_HALT:  return {31'd0, a_halted};
            A_PC4:   return a_pc4;
            B_PC:    return b_pc;
            B_IR:    return {30'd0, b_ir};
            B_MEXC:  return {31'd0, b_mexc};
            C_PC:    return c_pc;
            C_IR:    return c_ir;
            C_FREQ:  return {31'd0, c_freq};
            C_MEXC:  return {31'd0, c_mexc};
            C_BAD:   return c_bad;
            C_HALT:  return {31'd0, c_halted};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_state(input string tag);
        push({tag, ".a_pc"}, A_PC, e_pc_a);
        push({tag, ".a_ir"}, A_IR, e_ir_a);
        push({tag, ".b_pc"}, B_PC, e_pc_b);
        push({tag, ".b_ir"}, B_IR, {30'd0, e_ir_b});
        push({tag, ".c_pc"}, C_PC, e_pc_c);
        push({tag, ".c_ir"}, C_IR, e_ir_c);
    endtask

    task automatic adv_all(input logic [31:0] npc, input string tag);
        e_pc_a = npc;
        e_pc_b = npc;
        e_pc_c = npc;
        e_ir_a = e_ir_a + 1;
        e_ir_b = e_ir_b + 2'd1;
        e_ir_c = e_ir_c + 1;
        push_state(tag);
    endtask

    task automatic model_reset();
        e_pc_a = 32'h100; e_pc_b = 32'h100; e_pc_c = 32'h100;
        e_ir_a = 0;       e_ir_b = 2'd0;    e_ir_c = 0;
    endtask

    task automatic step();
        exp_t        e;
        logic [31:0] o;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            n_chk++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, o, e.val);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_src = 3'b000; fetch_gnt = 1'b1; irq_req = 1'b0;
        branch_target = '0; jal_target = '0; jalr_target = '0; epc = '0;
        trap_vec = 32'h0000_1003;
        model_reset();

        // Reset held two cycles
        push("rst.pc", A_PC, 32'h100);
        push("rst.ir", A_IR, 0);
        push("rst.freq", A_FREQ, 0);
        push("rst.halt", A_HALT, 0);
        push("rst.mexc", A_MEXC, 0);
        push("rst.bad", A_BAD, 0);
        step();
        push("rst2.freq", A_FREQ, 0);
        push("rst2.c_halt", C_HALT, 0);
        step();

        // Boot bubble, then sequential fetch; b's 2-bit counter wraps 3 -> 0
        rst = 1'b0;
        push("boot.freq", A_FREQ, 1);
        push("boot.pc4", A_PC4, 32'h104);
        push_state("boot");
        step();
        for (int i = 0; i < 4; i++) begin
            adv_all(e_pc_a + 32'd4, "seq");
            step();
        end

        pc_src = 3'b001; branch_target = 32'h200; adv_all(32'h200, "branch"); step();
        pc_src = 3'b011; jalr_target   = 32'h301; adv_all(32'h300, "jalr");   step();
        pc_src = 3'b100; epc           = 32'h400; adv_all(32'h400, "mret");   step();
        pc_src = 3'b111;                          adv_all(32'h404, "src7");   step();

        // Stall gating, then grant gating
        pc_src = 3'b001; branch_target = 32'h500; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin push_state("stall"); step(); end
        stall = 1'b0; adv_all(32'h500, "unstall"); step();
        fetch_gnt = 1'b0; branch_target = 32'h600;
        for (int i = 0; i < 3; i++) begin push_state("nognt"); step(); end
        fetch_gnt = 1'b1; adv_all(32'h600, "gnt"); step();

        // Misaligned JAL: a traps, b (IALIGN=16) takes it, c halts
        pc_src = 3'b010; jal_target = 32'h206;
        e_pc_a = 32'h1000;
        e_pc_b = 32'h206; e_ir_b = e_ir_b + 2'd1;
        push_state("mis");
        push("mis.a_bad", A_BAD, 32'h206);
        push("mis.a_mexc", A_MEXC, 1);
        push("mis.b_mexc", B_MEXC, 0);
        push("mis.c_mexc", C_MEXC, 1);
        push("mis.c_bad", C_BAD, 32'h206);
        push("mis.c_halt", C_HALT, 1);
        push("mis.c_freq", C_FREQ, 0);
        step();
        pc_src = 3'b000;
        e_pc_a = 32'h1004; e_ir_a = e_ir_a + 1;
        e_pc_b = 32'h20A;  e_ir_b = e_ir_b + 2'd1;
        push_state("postmis");
        push("postmis.a_mexc", A_MEXC, 0);
        push("postmis.c_mexc", C_MEXC, 0);
        step();

        // c stays halted despite grant and interrupt pulses
        for (int i = 0; i < 10; i++) begin
            irq_req = (i % 2) == 0;
            push("halt.c_pc", C_PC, e_pc_c);
            push("halt.c_ir", C_IR, e_ir_c);
            push("halt.c_halt", C_HALT, 1);
            push("halt.c_freq", C_FREQ, 0);
            step();
        end
        irq_req = 1'b0;

        // Reset recovers to BOOT
        rst = 1'b1;
        model_reset();
        push("rec.c_halt", C_HALT, 0);
        push("rec.c_freq", C_FREQ, 0);
        push("rec.c_pc", C_PC, 32'h100);
        push("rec.a_ir", A_IR, 0);
        step();
        rst = 1'b0;
        push("rec.a_freq", A_FREQ, 1);
        push("rec.c_freq", C_FREQ, 1);
        step();

        // Interrupt latched during stall beats a later misaligned target
        stall = 1'b1; irq_req = 1'b1; push_state("irqlatch"); step();
        irq_req = 1'b0;               push_state("irqhold");  step();
        stall = 1'b0; pc_src = 3'b010; jal_target = 32'h206;
        e_pc_a = 32'h1000; e_pc_b = 32'h1002; e_pc_c = 32'h1000;
        e_ir_a = e_ir_a + 1; e_ir_b = e_ir_b + 2'd1; e_ir_c = e_ir_c + 1;
        push_state("irqwin");
        push("irqwin.a_mexc", A_MEXC, 0);
        push("irqwin.c_mexc", C_MEXC, 0);
        push("irqwin.c_halt", C_HALT, 0);
        step();
        pc_src = 3'b000;
        e_pc_a = 32'h1004; e_pc_b = 32'h1006; e_pc_c = 32'h1004;
        e_ir_a = e_ir_a + 1; e_ir_b = e_ir_b + 2'd1; e_ir_c = e_ir_c + 1;
        push_state("irqclr");
        step();

        // PC wraps modulo 2^32
        pc_src = 3'b001; branch_target = 32'hFFFF_FFFC;
        adv_all(32'hFFFF_FFFC, "top");
        push("top.pc4", A_PC4, 32'h0);
        step();
        pc_src = 3'b000;
        adv_all(32'h0, "wrap");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
